i4002_host_seq: RTL

Host-side bus sequencer for a single bank of i4002 RAM chips. It turns word-level host requests (RAM character, status character, output-port write) into the MCS-4 instruction-cycle waveforms (sync, cm_ram, data bus) the i4002 expects. It lets the PYNQ host load and inspect RAM contents without an i4004 on the bus. It generates free-running 8-phase cycles, an SRC cycle to select the address, then an I/O cycle carrying the OPA and data, with an optional address cache that skips redundant SRC cycles.

---
 rtl/i4002_host_seq_if.sv | 23 ++
 rtl/i4002_host_seq.sv | 132 +++++++++++++
 2 files changed

// File: rtl/i4002_host_seq_if.sv
// Host-side request/response handshake for the i4002 bus sequencer.
// The host drives requests and accepts responses; the sequencer does the reverse.
interface i4002_host_seq_if;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_op;
   logic [7:0] req_addr;
   logic [3:0] req_wdata;
   logic       resp_valid;
   logic       resp_ready;
   logic [3:0] resp_rdata;
   logic       resp_err;

   modport master (
      output req_valid, req_op, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/i4002_host_seq.sv
// Turns word-level host requests into MCS-4 SRC/IO instruction cycles for a bank
// of i4002 RAMs, with a free-running 8-phase counter and optional SRC address cache.
module i4002_host_seq #(
   parameter bit ADDR_CACHE = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   i4002_host_seq_if.slave  host,
   output logic             sync_o,
   output logic             cm_ram_o,
   output logic [3:0]       dbus_out_o,
   input  logic [3:0]       dbus_in_i
);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SRC, S_IO, S_RESP} state_e;

   localparam logic [2:0] PH_M2 = 3'd4;
   localparam logic [2:0] PH_X2 = 3'd6;
   localparam logic [2:0] PH_X3 = 3'd7;

   state_e     state_q, state_d;
   logic [2:0] ph_q;
   logic [3:0] op_q, op_d;
   logic [7:0] addr_q, addr_d;
   logic [3:0] wdata_q, wdata_d;
   logic [7:0] last_addr_q, last_addr_d;
   logic       cache_vld_q, cache_vld_d;
   logic [3:0] rdata_q, rdata_d;
   logic       err_q, err_d;

   function automatic logic is_unsup(input logic [3:0] op);
      return (op == 4'h2) || (op == 4'h3) || (op == 4'hA);
   endfunction

   function automatic logic is_read(input logic [3:0] op);
      return op[3] && (op != 4'hA);
   endfunction

   // A cycle boundary decides whether the next cycle is SRC or can go straight to IO.
   function automatic state_e cycle_start(input logic [7:0] a);
      return (ADDR_CACHE && cache_vld_q && (a == last_addr_q)) ? S_IO : S_SRC;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ph_q        <= PH_X3;
         op_q        <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         last_addr_q <= '0;
         cache_vld_q <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ph_q        <= ph_q + 3'd1;
         op_q        <= op_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         last_addr_q <= last_addr_d;
         cache_vld_q <= cache_vld_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      last_addr_d = last_addr_q;
      cache_vld_d = cache_vld_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      cm_ram_o    = 1'b0;
      dbus_out_o  = 4'h0;
      unique case (state_q)
         S_IDLE: begin
            if (host.req_valid) begin
               op_d    = host.req_op;
               addr_d  = host.req_addr;
               wdata_d = host.req_wdata;
               rdata_d = 4'h0;
               err_d   = is_unsup(host.req_op);
               if (is_unsup(host.req_op)) state_d = S_RESP;
               else if (ph_q == PH_X3)    state_d = cycle_start(host.req_addr);
               else                       state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (ph_q == PH_X3) state_d = cycle_start(addr_q);
         end
         S_SRC: begin
            if (ph_q == PH_X2) begin
               cm_ram_o   = 1'b1;
               dbus_out_o = addr_q[7:4];
            end
            if (ph_q == PH_X3) begin
               dbus_out_o  = addr_q[3:0];
               last_addr_d = addr_q;
               cache_vld_d = 1'b1;
               state_d     = S_IO;
            end
         end
         S_IO: begin
            if (ph_q == PH_M2) begin
               cm_ram_o   = 1'b1;
               dbus_out_o = op_q;
            end
            // cm_ram must be low at X2 or the RAMs would re-latch an address.
            if (ph_q == PH_X2) begin
               dbus_out_o = is_read(op_q) ? 4'h0 : wdata_q;
               if (is_read(op_q)) rdata_d = dbus_in_i;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (host.resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign sync_o          = (ph_q == PH_X3);
   assign host.req_ready  = (state_q == S_IDLE);
   assign host.resp_valid = (state_q == S_RESP);
   assign host.resp_rdata = rdata_q;
   assign host.resp_err   = err_q;

endmodule
